// File: rtl/coeff_section_ctrl.sv
// Sequencing controller ahead of the ADC-section classifier: classifies each
// accepted ADC count against a programmable limit, debounces section changes
// and presents the coefficient for the committed section.
module coeff_section_ctrl #(
  parameter int DEB_LEN = 4,
  parameter int COEFF_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_valid_i,
  output logic               sample_ready_o,
  input  logic [20:0]        adc_count_i,
  input  logic               limit_wr_i,
  input  logic [19:0]        limit_i,
  input  logic               coeff_wr_i,
  input  logic [1:0]         coeff_addr_i,
  input  logic [COEFF_W-1:0] coeff_data_i,
  output logic [1:0]         section_o,
  output logic               section_chg_o,
  output logic [COEFF_W-1:0] coeff_o,
  output logic               coeff_valid_o
);

  typedef enum logic [1:0] {
    IDLE,
    CLASSIFY,
    EVAL,
    OUTPUT
  } state_t;

  localparam logic [3:0] DEB_CNT = 4'(DEB_LEN);

  state_t             state_q, state_d;
  logic [20:0]        sample_q;
  logic [19:0]        limit_shadow_q;
  logic [19:0]        limit_act_q;
  logic [1:0]         cand_q;
  logic [1:0]         pending_q;
  logic [1:0]         section_q;
  logic [3:0]         count_q;
  logic [COEFF_W-1:0] coeff_q;
  logic               chg_q;
  logic [COEFF_W-1:0] bank_q [4];

  logic [21:0]        sample_sext;
  logic [21:0]        sample_abs;
  logic [21:0]        limit_ext;
  logic               sample_pos;
  logic [1:0]         cand_d;

  logic [1:0]         pending_d;
  logic [1:0]         section_d;
  logic [3:0]         count_d;
  logic               commit;
  logic [COEFF_W-1:0] coeff_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    sample_ready_o = 1'b0;
    coeff_valid_o  = 1'b0;
    case (state_q)
      IDLE: begin
        sample_ready_o = 1'b1;
        if (sample_valid_i) begin
          state_d = CLASSIFY;
        end
      end
      CLASSIFY: state_d = EVAL;
      EVAL:     state_d = OUTPUT;
      OUTPUT: begin
        coeff_valid_o = 1'b1;
        state_d       = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  // Magnitude is 22 bits wide so the most negative count stays positive.
  always_comb begin
    sample_sext = {sample_q[20], sample_q};
    sample_abs  = sample_q[20] ? (~sample_sext + 22'd1) : sample_sext;
    limit_ext   = {2'b00, limit_act_q};
    sample_pos  = !sample_q[20] && (sample_q != '0);
    cand_d      = 2'b01;
    if (sample_pos) begin
      cand_d = (sample_abs > limit_ext) ? 2'b11 : 2'b10;
    end else begin
      cand_d = (sample_abs <= limit_ext) ? 2'b01 : 2'b00;
    end
  end

  always_comb begin
    pending_d = pending_q;
    section_d = section_q;
    count_d   = count_q;
    commit    = 1'b0;
    if (cand_q == section_q) begin
      count_d   = '0;
      pending_d = section_q;
    end else if (cand_q != pending_q) begin
      pending_d = cand_q;
      count_d   = 4'd1;
    end else begin
      count_d = count_q + 4'd1;
    end
    if (count_d == DEB_CNT) begin
      section_d = pending_d;
      count_d   = '0;
      commit    = 1'b1;
    end
    // A bank write landing on the entry being read this cycle is forwarded.
    coeff_d = (coeff_wr_i && (coeff_addr_i == section_d)) ? coeff_data_i : bank_q[section_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q    <= '0;
      limit_act_q <= '0;
      cand_q      <= 2'b01;
    end else begin
      if (state_q == IDLE && sample_valid_i) begin
        sample_q    <= adc_count_i;
        limit_act_q <= limit_shadow_q;
      end
      if (state_q == CLASSIFY) begin
        cand_q <= cand_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 2'b01;
      section_q <= 2'b01;
      count_q   <= '0;
      coeff_q   <= '0;
      chg_q     <= 1'b0;
    end else begin
      chg_q <= (state_q == EVAL) && commit;
      if (state_q == EVAL) begin
        pending_q <= pending_d;
        section_q <= section_d;
        count_q   <= count_d;
        coeff_q   <= coeff_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit_shadow_q <= '0;
      for (int i = 0; i < 4; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      if (limit_wr_i) begin
        limit_shadow_q <= limit_i;
      end
      if (coeff_wr_i) begin
        bank_q[coeff_addr_i] <= coeff_data_i;
      end
    end
  end

  assign section_o     = section_q;
  assign section_chg_o = chg_q;
  assign coeff_o       = coeff_q;

endmodule
